// File: rtl/axi4_lite_interconnect_1xn.sv
// AXI4-Lite 1-master to N-slave interconnect: fixed-window address decode,
// one outstanding write and one outstanding read, internal DECERR with a counter.
module axi4_lite_interconnect_1xn #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SLAVES  = 4,
  parameter int SLAVE_SHIFT = 12
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [ADDR_WIDTH-1:0]            s_awaddr,
  input  logic [2:0]                       s_awprot,
  input  logic                             s_awvalid,
  output logic                             s_awready,
  input  logic [DATA_WIDTH-1:0]            s_wdata,
  input  logic [DATA_WIDTH/8-1:0]          s_wstrb,
  input  logic                             s_wvalid,
  output logic                             s_wready,
  output logic [1:0]                       s_bresp,
  output logic                             s_bvalid,
  input  logic                             s_bready,
  input  logic [ADDR_WIDTH-1:0]            s_araddr,
  input  logic [2:0]                       s_arprot,
  input  logic                             s_arvalid,
  output logic                             s_arready,
  output logic [DATA_WIDTH-1:0]            s_rdata,
  output logic [1:0]                       s_rresp,
  output logic                             s_rvalid,
  input  logic                             s_rready,
  output logic [ADDR_WIDTH-1:0]            m_awaddr,
  output logic [2:0]                       m_awprot,
  output logic [NUM_SLAVES-1:0]            m_awvalid,
  input  logic [NUM_SLAVES-1:0]            m_awready,
  output logic [DATA_WIDTH-1:0]            m_wdata,
  output logic [DATA_WIDTH/8-1:0]          m_wstrb,
  output logic [NUM_SLAVES-1:0]            m_wvalid,
  input  logic [NUM_SLAVES-1:0]            m_wready,
  input  logic [2*NUM_SLAVES-1:0]          m_bresp,
  input  logic [NUM_SLAVES-1:0]            m_bvalid,
  output logic [NUM_SLAVES-1:0]            m_bready,
  output logic [ADDR_WIDTH-1:0]            m_araddr,
  output logic [2:0]                       m_arprot,
  output logic [NUM_SLAVES-1:0]            m_arvalid,
  input  logic [NUM_SLAVES-1:0]            m_arready,
  input  logic [DATA_WIDTH*NUM_SLAVES-1:0] m_rdata,
  input  logic [2*NUM_SLAVES-1:0]          m_rresp,
  input  logic [NUM_SLAVES-1:0]            m_rvalid,
  output logic [NUM_SLAVES-1:0]            m_rready,
  output logic [15:0]                      decerr_count
);
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TOP   = SLAVE_SHIFT + IDX_W;

  typedef enum logic [2:0] {W_IDLE, W_FWD, W_RESP, W_ERR, W_DEC} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP, R_DEC} rstate_e;

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[SLAVE_SHIFT +: IDX_W];
  endfunction

  function automatic logic addr_mapped(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] hi;
    hi = a >> TOP;
    return (hi == '0) && ({1'b0, a[SLAVE_SHIFT +: IDX_W]} < (IDX_W+1)'(NUM_SLAVES));
  endfunction

  // Compare against every legal index so an out-of-range index selects nothing.
  function automatic logic [NUM_SLAVES-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_SLAVES-1:0] oh;
    for (int i = 0; i < NUM_SLAVES; i++) oh[i] = (idx == IDX_W'(i));
    return oh;
  endfunction

  wstate_e                 wstate_q, wstate_d;
  rstate_e                 rstate_q, rstate_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [2:0]              awprot_q, awprot_d, arprot_q, arprot_d;
  logic [IDX_W-1:0]        wsel_q, wsel_d, rsel_q, rsel_d;
  logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                    rdy_en_q;
  logic [15:0]             decerr_q, decerr_d;

  logic [NUM_SLAVES-1:0]   wsel_oh, rsel_oh;
  logic                    sel_wready, sel_bvalid, sel_rvalid;
  logic [1:0]              sel_bresp, sel_rresp;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    aw_hs, w_hs;
  logic [1:0]              dec_inc;
  logic [16:0]             dec_sum;

  assign wsel_oh      = onehot(wsel_q);
  assign rsel_oh      = onehot(rsel_q);
  assign m_awaddr     = awaddr_q;
  assign m_awprot     = awprot_q;
  assign m_wdata      = s_wdata;
  assign m_wstrb      = s_wstrb;
  assign m_araddr     = araddr_q;
  assign m_arprot     = arprot_q;
  assign decerr_count = decerr_q;
  assign aw_hs        = |(m_awvalid & m_awready);
  assign w_hs         = |(m_wvalid & m_wready);

  always_comb begin
    sel_wready = |(m_wready & wsel_oh);
    sel_bvalid = |(m_bvalid & wsel_oh);
    sel_rvalid = |(m_rvalid & rsel_oh);
    sel_bresp  = '0;
    sel_rresp  = '0;
    sel_rdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (wsel_oh[i]) sel_bresp = m_bresp[2*i +: 2];
      if (rsel_oh[i]) begin
        sel_rresp = m_rresp[2*i +: 2];
        sel_rdata = m_rdata[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_en_q  <= 1'b0;
      awaddr_q  <= '0;
      awprot_q  <= '0;
      wsel_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      araddr_q  <= '0;
      arprot_q  <= '0;
      rsel_q    <= '0;
      decerr_q  <= '0;
    end else begin
      rdy_en_q  <= 1'b1;
      awaddr_q  <= awaddr_d;
      awprot_q  <= awprot_d;
      wsel_q    <= wsel_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      araddr_q  <= araddr_d;
      arprot_q  <= arprot_d;
      rsel_q    <= rsel_d;
      decerr_q  <= decerr_d;
    end
  end

  // Write next-state and AW latch
  always_comb begin
    wstate_d  = wstate_q;
    awaddr_d  = awaddr_q;
    awprot_d  = awprot_q;
    wsel_d    = wsel_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (wstate_q)
      W_IDLE: if (s_awvalid && s_awready) begin
        awaddr_d  = s_awaddr;
        awprot_d  = s_awprot;
        wsel_d    = addr_idx(s_awaddr);
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        wstate_d  = addr_mapped(s_awaddr) ? W_FWD : W_ERR;
      end
      W_FWD: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) wstate_d = W_RESP;
      end
      W_RESP:  if (s_bvalid && s_bready) wstate_d = W_IDLE;
      W_ERR:   if (s_wvalid) wstate_d = W_DEC;
      W_DEC:   if (s_bready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    s_awready = rdy_en_q && (wstate_q == W_IDLE);
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bresp   = '0;
    m_awvalid = '0;
    m_wvalid  = '0;
    m_bready  = '0;
    case (wstate_q)
      W_FWD: begin
        m_awvalid = aw_done_q ? '0 : wsel_oh;
        m_wvalid  = (w_done_q || !s_wvalid) ? '0 : wsel_oh;
        s_wready  = !w_done_q && sel_wready;
      end
      W_RESP: begin
        s_bvalid = sel_bvalid;
        s_bresp  = sel_bresp;
        m_bready = s_bready ? wsel_oh : '0;
      end
      W_ERR: s_wready = 1'b1;
      W_DEC: begin
        s_bvalid = 1'b1;
        s_bresp  = 2'b11;
      end
      default: ;
    endcase
  end

  // Read next-state and AR latch
  always_comb begin
    rstate_d = rstate_q;
    araddr_d = araddr_q;
    arprot_d = arprot_q;
    rsel_d   = rsel_q;
    case (rstate_q)
      R_IDLE: if (s_arvalid && s_arready) begin
        araddr_d = s_araddr;
        arprot_d = s_arprot;
        rsel_d   = addr_idx(s_araddr);
        rstate_d = addr_mapped(s_araddr) ? R_FWD : R_DEC;
      end
      R_FWD:   if (|(m_arvalid & m_arready)) rstate_d = R_RESP;
      R_RESP:  if (s_rvalid && s_rready) rstate_d = R_IDLE;
      R_DEC:   if (s_rready) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    s_arready = rdy_en_q && (rstate_q == R_IDLE);
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rresp   = '0;
    m_arvalid = '0;
    m_rready  = '0;
    case (rstate_q)
      R_FWD: m_arvalid = rsel_oh;
      R_RESP: begin
        s_rvalid = sel_rvalid;
        s_rdata  = sel_rdata;
        s_rresp  = sel_rresp;
        m_rready = s_rready ? rsel_oh : '0;
      end
      R_DEC: begin
        s_rvalid = 1'b1;
        s_rresp  = 2'b11;
      end
      default: ;
    endcase
  end

  // Write and read DECERRs may retire in the same cycle, so add up to 2.
  always_comb begin
    dec_inc  = {1'b0, (wstate_q == W_DEC) && s_bready} + {1'b0, (rstate_q == R_DEC) && s_rready};
    dec_sum  = {1'b0, decerr_q} + {15'd0, dec_inc};
    decerr_d = dec_sum[16] ? 16'hFFFF : dec_sum[15:0];
  end

endmodule

// File: tb/tb_axi4_lite_interconnect_1xn.sv
// Directed bench for the 1xN AXI4-Lite interconnect (4 slaves, 4 KiB windows).
module tb_axi4_lite_interconnect_1xn;
  localparam int AW = 32, DW = 32, NS = 4;

  logic            aclk = 1'b0, aresetn = 1'b0;
  logic [AW-1:0]   s_awaddr, s_araddr, m_awaddr, m_araddr;
  logic [2:0]      s_awprot, s_arprot, m_awprot, m_arprot;
  logic            s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic            s_arvalid, s_arready, s_rvalid, s_rready;
  logic [DW-1:0]   s_wdata, s_rdata, m_wdata;
  logic [DW/8-1:0] s_wstrb, m_wstrb;
  logic [1:0]      s_bresp, s_rresp;
  logic [NS-1:0]   m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [NS-1:0]   m_arvalid, m_arready, m_rvalid, m_rready;
  logic [2*NS-1:0] m_bresp, m_rresp;
  logic [DW*NS-1:0] m_rdata;
  logic [15:0]     decerr_count;

  int checks = 0, errors = 0, w_hs_cnt = 0, w_base;

  always #5 aclk = ~aclk;
  always @(posedge aclk) if (|(m_wvalid & m_wready)) w_hs_cnt <= w_hs_cnt + 1;

  axi4_lite_interconnect_1xn #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SLAVE_SHIFT(12)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .decerr_count(decerr_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic clr_slaves();
    m_awready = '0; m_wready = '0; m_bvalid = '0; m_bresp = '0;
    m_arready = '0; m_rvalid = '0; m_rresp = '0; m_rdata = '0;
  endtask

  initial begin
    s_awaddr = '0; s_awprot = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
    s_bready = 0; s_araddr = '0; s_arprot = '0; s_arvalid = 0; s_rready = 0;
    clr_slaves();

    // Reset state
    tick(); tick();
    chk("rst_awready", s_awready, 0);
    chk("rst_arready", s_arready, 0);
    chk("rst_wready", s_wready, 0);
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_decerr", decerr_count, 0);
    aresetn = 1;
    chk("rel_awready_before_edge", s_awready, 0);
    tick();
    chk("rel_awready", s_awready, 1);
    chk("rel_arready", s_arready, 1);

    // Mapped write to slave 1
    s_awaddr = 32'h1004; s_awprot = 3'b010; s_awvalid = 1;
    s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_wvalid = 1;
    #1 chk("wr_wready_idle", s_wready, 0);
    tick(); s_awvalid = 0; #1;
    chk("wr_m_awvalid", m_awvalid, 4'b0010);
    chk("wr_m_wvalid", m_wvalid, 4'b0010);
    chk("wr_m_wdata", m_wdata, 32'hDEADBEEF);
    chk("wr_m_awaddr", m_awaddr, 32'h1004);
    chk("wr_m_awprot", m_awprot, 3'b010);
    chk("wr_awready_busy", s_awready, 0);
    m_awready = 4'b0010; m_wready = 4'b0010;
    #1 chk("wr_s_wready", s_wready, 1);
    tick(); s_wvalid = 0; clr_slaves(); #1;
    chk("wr_resp_m_awvalid", m_awvalid, 0);
    chk("wr_resp_bvalid_wait", s_bvalid, 0);
    m_bvalid = 4'b0010; m_bresp = 8'b00_00_00_10; s_bready = 1;
    #1 chk("wr_bvalid", s_bvalid, 1);
    chk("wr_bresp", s_bresp, 2'b00);
    chk("wr_m_bready", m_bready, 4'b0010);
    tick(); s_bready = 0; clr_slaves(); #1;
    chk("wr_done_bvalid", s_bvalid, 0);
    chk("wr_done_awready", s_awready, 1);

    // Mapped read from slave 3
    s_araddr = 32'h3008; s_arvalid = 1;
    tick(); s_arvalid = 0; #1;
    chk("rd_m_arvalid", m_arvalid, 4'b1000);
    chk("rd_m_araddr", m_araddr, 32'h3008);
    m_arready = 4'b1000;
    tick(); clr_slaves(); #1;
    chk("rd_resp_m_arvalid", m_arvalid, 0);
    m_rdata = {32'hA5A50003, 32'h11110002, 32'h11110001, 32'h11110000};
    m_rresp = 8'b00_10_10_10; m_rvalid = 4'b1000; s_rready = 1;
    #1 chk("rd_rvalid", s_rvalid, 1);
    chk("rd_rdata", s_rdata, 32'hA5A50003);
    chk("rd_rresp", s_rresp, 2'b00);
    chk("rd_m_rready", m_rready, 4'b1000);
    tick(); s_rready = 0; clr_slaves(); #1;
    chk("rd_done_arready", s_arready, 1);

    // Unmapped write 0x8000 and read 0x5000, both retired in the same cycle
    s_awaddr = 32'h8000; s_awvalid = 1;
    tick(); s_awvalid = 0; #1;
    chk("dw_m_awvalid", m_awvalid, 0);
    chk("dw_wready", s_wready, 1);
    chk("dw_bvalid_early", s_bvalid, 0);
    s_wvalid = 1; s_wdata = 32'h0BAD0BAD;
    #1 chk("dw_m_wvalid", m_wvalid, 0);
    tick(); s_wvalid = 0; #1;
    chk("dw_bvalid", s_bvalid, 1);
    chk("dw_bresp", s_bresp, 2'b11);
    s_araddr = 32'h5000; s_arvalid = 1;
    tick(); s_arvalid = 0; #1;
    chk("dr_rvalid", s_rvalid, 1);
    chk("dr_rresp", s_rresp, 2'b11);
    chk("dr_rdata", s_rdata, 0);
    chk("dr_m_arvalid", m_arvalid, 0);
    chk("dec_count_hold", decerr_count, 0);
    s_bready = 1; s_rready = 1;
    tick(); s_bready = 0; s_rready = 0; #1;
    chk("dec_count_2", decerr_count, 16'd2);
    chk("dec_bvalid_off", s_bvalid, 0);
    chk("dec_rvalid_off", s_rvalid, 0);

    // W presented before AW, AW ready delayed, W ready immediate
    w_base = w_hs_cnt;
    s_wvalid = 1; s_wdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      #1 chk("ord_wready_idle", s_wready, 0);
      chk("ord_m_wvalid_idle", m_wvalid, 0);
      tick();
    end
    s_awaddr = 32'h2010; s_awvalid = 1;
    tick(); s_awvalid = 0; m_wready = 4'b0100; #1;
    chk("ord_m_awvalid", m_awvalid, 4'b0100);
    chk("ord_m_wvalid", m_wvalid, 4'b0100);
    chk("ord_wready", s_wready, 1);
    tick(); #1;
    chk("ord_m_wvalid_done", m_wvalid, 0);
    chk("ord_wready_done", s_wready, 0);
    chk("ord_m_awvalid_hold", m_awvalid, 4'b0100);
    tick(); tick(); #1;
    chk("ord_m_awvalid_hold2", m_awvalid, 4'b0100);
    m_awready = 4'b0100;
    tick(); s_wvalid = 0; clr_slaves(); #1;
    chk("ord_m_awvalid_off", m_awvalid, 0);
    chk("ord_w_hs_count", w_hs_cnt - w_base, 1);
    m_bvalid = 4'b0100; m_bresp = 8'b11_01_11_11; s_bready = 1;
    #1 chk("ord_bvalid", s_bvalid, 1);
    chk("ord_bresp", s_bresp, 2'b01);
    tick(); s_bready = 0; clr_slaves(); #1;
    chk("ord_bvalid_off", s_bvalid, 0);
    chk("ord_awready", s_awready, 1);

    // Concurrent write to slave 0 and read from slave 2
    s_awaddr = 32'h20; s_awvalid = 1; s_wvalid = 1; s_wdata = 32'h55AA55AA;
    s_araddr = 32'h2004; s_arvalid = 1;
    tick(); s_awvalid = 0; s_arvalid = 0; #1;
    chk("cc_m_awvalid", m_awvalid, 4'b0001);
    chk("cc_m_arvalid", m_arvalid, 4'b0100);
    m_awready = 4'b0001; m_wready = 4'b0001; m_arready = 4'b0100;
    tick(); s_wvalid = 0; clr_slaves(); #1;
    m_bvalid = 4'b0001; m_bresp = 8'b10_10_10_00;
    m_rvalid = 4'b0100; m_rresp = 8'b10_00_10_10;
    m_rdata = {32'h00000003, 32'hCAFE0002, 32'h00000001, 32'h00000000};
    s_bready = 1; s_rready = 1;
    #1 chk("cc_bvalid", s_bvalid, 1);
    chk("cc_bresp", s_bresp, 2'b00);
    chk("cc_rvalid", s_rvalid, 1);
    chk("cc_rdata", s_rdata, 32'hCAFE0002);
    chk("cc_rresp", s_rresp, 2'b00);
    tick(); s_bready = 0; s_rready = 0; clr_slaves(); #1;
    chk("cc_awready", s_awready, 1);
    chk("cc_arready", s_arready, 1);
    chk("cc_decerr_same", decerr_count, 16'd2);

    // Async reset while waiting in W_RESP
    s_awaddr = 32'h3000; s_awvalid = 1; s_wvalid = 1;
    tick(); s_awvalid = 0; m_awready = 4'b1000; m_wready = 4'b1000;
    tick(); s_wvalid = 0; clr_slaves(); m_bvalid = 4'b1000; #1;
    chk("mr_bvalid_pre", s_bvalid, 1);
    aresetn = 0; #1;
    chk("mr_bvalid", s_bvalid, 0);
    chk("mr_awready", s_awready, 0);
    chk("mr_arready", s_arready, 0);
    chk("mr_m_bready", m_bready, 0);
    chk("mr_decerr", decerr_count, 0);
    #2 aresetn = 1; #1;
    chk("mr_awready_before_edge", s_awready, 0);
    tick();
    chk("mr_awready_after", s_awready, 1);
    chk("mr_bvalid_idle", s_bvalid, 0);
    clr_slaves();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
